// File: rtl/karatsuba64_seq_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : karatsuba64_seq_ctrl_if
// Brief    : Handshake and shared-multiplier bus for the 64x64 Karatsuba
//            sequencing controller. The slave modport is the controller's view.
// Revision : 1.0 - initial release
// ============================================================================
interface karatsuba64_seq_ctrl_if #(
  parameter int W = 64
);
  localparam int H = W / 2;

  // Operand intake
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   a;
  logic [W-1:0]   b;

  // Result delivery
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] p;
  logic           busy;

  // Shared half-width multiplier
  logic [H-1:0]   mul_x;
  logic [H-1:0]   mul_y;
  logic [2*H-1:0] mul_p;

  // Request source / multiplier side
  modport master (
    output in_valid, a, b, out_ready, mul_p,
    input  in_ready, out_valid, p, busy, mul_x, mul_y
  );

  // Controller side
  modport slave (
    input  in_valid, a, b, out_ready, mul_p,
    output in_ready, out_valid, p, busy, mul_x, mul_y
  );
endinterface
`default_nettype wire

// File: rtl/karatsuba64_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : karatsuba64_seq_ctrl
// Brief    : W x W -> 2W multiply using one Karatsuba pass over a shared
//            H x H combinational multiplier, three products in three cycles,
//            followed by a signed-safe recombination and a result hold stage.
// Revision : 1.0 - initial release
// ============================================================================
module karatsuba64_seq_ctrl #(
  parameter int W = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  karatsuba64_seq_ctrl_if.slave bus
);

  localparam int H  = W / 2;
  // Two guard bits so the middle term can go negative without losing the sign
  localparam int WX = 2 * W + 2;

  localparam logic [2:0] C_IDLE    = 3'd0;
  localparam logic [2:0] C_MUL_LL  = 3'd1;
  localparam logic [2:0] C_MUL_HH  = 3'd2;
  localparam logic [2:0] C_MUL_MID = 3'd3;
  localparam logic [2:0] C_COMBINE = 3'd4;
  localparam logic [2:0] C_DONE    = 3'd5;

  logic [2:0]     r_state;
  logic [H-1:0]   r_a_h;
  logic [H-1:0]   r_b_h;
  logic [H-1:0]   r_ra;
  logic [H-1:0]   r_rb;
  logic           r_ca;
  logic           r_cb;
  logic [2*H-1:0] r_p_ll;
  logic [2*H-1:0] r_p_hh;
  logic [2*H-1:0] r_p_rr;
  logic [2*W-1:0] r_p;
  logic [H-1:0]   r_mul_x;
  logic [H-1:0]   r_mul_y;

  // Half sums of the incoming operands; the carry bit is kept separately
  // because the shared multiplier is only H bits wide.
  logic [H:0] w_sa;
  logic [H:0] w_sb;
  assign w_sa = {1'b0, bus.a[H-1:0]} + {1'b0, bus.a[W-1:H]};
  assign w_sb = {1'b0, bus.b[H-1:0]} + {1'b0, bus.b[W-1:H]};

  // Recombination: m = (sa*sb) rebuilt from the H-bit product plus carry
  // corrections, mid = m - p_ll - p_hh (may be negative with an approximate
  // multiplier), then the shifted sum wraps to 2W bits.
  logic [WX-1:0]  w_ll;
  logic [WX-1:0]  w_hh;
  logic [WX-1:0]  w_rr;
  logic [WX-1:0]  w_cross;
  logic [WX-1:0]  w_m;
  logic [WX-1:0]  w_mid;
  logic [2*W-1:0] w_p;

  assign w_ll    = WX'(r_p_ll);
  assign w_hh    = WX'(r_p_hh);
  assign w_rr    = WX'(r_p_rr);
  assign w_cross = WX'(r_ca ? r_rb : {H{1'b0}}) + WX'(r_cb ? r_ra : {H{1'b0}});
  assign w_m     = w_rr + (w_cross << H) + (WX'(r_ca & r_cb) << W);
  assign w_mid   = w_m - w_ll - w_hh;
  assign w_p     = (2*W)'((w_hh << W) + (w_mid << H) + w_ll);

  // Sequencer: operand capture, multiplier operand scheduling, product capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= C_IDLE;
      r_a_h   <= '0;
      r_b_h   <= '0;
      r_ra    <= '0;
      r_rb    <= '0;
      r_ca    <= 1'b0;
      r_cb    <= 1'b0;
      r_p_ll  <= '0;
      r_p_hh  <= '0;
      r_p_rr  <= '0;
      r_p     <= '0;
      r_mul_x <= '0;
      r_mul_y <= '0;
    end else begin
      case (r_state)
        C_IDLE: begin
          if (bus.in_valid) begin
            r_a_h   <= bus.a[W-1:H];
            r_b_h   <= bus.b[W-1:H];
            r_ca    <= w_sa[H];
            r_ra    <= w_sa[H-1:0];
            r_cb    <= w_sb[H];
            r_rb    <= w_sb[H-1:0];
            r_mul_x <= bus.a[H-1:0];
            r_mul_y <= bus.b[H-1:0];
            r_state <= C_MUL_LL;
          end
        end
        C_MUL_LL: begin
          r_p_ll  <= bus.mul_p;
          r_mul_x <= r_a_h;
          r_mul_y <= r_b_h;
          r_state <= C_MUL_HH;
        end
        C_MUL_HH: begin
          r_p_hh  <= bus.mul_p;
          r_mul_x <= r_ra;
          r_mul_y <= r_rb;
          r_state <= C_MUL_MID;
        end
        C_MUL_MID: begin
          r_p_rr  <= bus.mul_p;
          r_state <= C_COMBINE;
        end
        C_COMBINE: begin
          r_p     <= w_p;
          r_state <= C_DONE;
        end
        C_DONE: begin
          if (bus.out_ready) begin
            r_state <= C_IDLE;
          end
        end
        default: r_state <= C_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (r_state == C_IDLE);
  assign bus.busy      = (r_state != C_IDLE);
  assign bus.out_valid = (r_state == C_DONE);
  assign bus.p         = r_p;
  assign bus.mul_x     = r_mul_x;
  assign bus.mul_y     = r_mul_y;

endmodule
`default_nettype wire

// File: tb/tb_karatsuba64_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_karatsuba64_seq_ctrl
// Brief    : Self-checking bench: directed cases with an exact multiplier,
//            backpressure, mid-operation reset, and random operands with an
//            approximate multiplier against an error-propagation model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_karatsuba64_seq_ctrl;

  logic clk;
  logic rst_n;
  logic use_approx;
  int   n_checks;
  int   n_errors;
  logic [31:0] mx [1:3];

  karatsuba64_seq_ctrl_if #(.W(64)) bus ();

  karatsuba64_seq_ctrl #(.W(64)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Approximate multiplier stand-in: exact product with the low byte replaced
  function automatic logic [63:0] mulf(input logic [31:0] x, input logic [31:0] y,
                                       input logic approx);
    logic [63:0] e;
    e = 64'(x) * 64'(y);
    if (approx) e[7:0] = x[7:0] ^ y[7:0];
    return e;
  endfunction

  assign bus.mul_p = mulf(bus.mul_x, bus.mul_y, use_approx);

  // Reference: true product plus the propagated error of each partial product.
  // p = a*b + e_ll*(1 - 2^32) + e_hh*(2^64 - 2^32) + e_rr*2^32  (mod 2^128)
  function automatic logic [127:0] model(input logic [63:0] a, input logic [63:0] b,
                                         input logic approx);
    logic [32:0]  sa, sb;
    logic [127:0] e_ll, e_hh, e_rr, r;
    sa   = 33'(a[31:0]) + 33'(a[63:32]);
    sb   = 33'(b[31:0]) + 33'(b[63:32]);
    e_ll = 128'(mulf(a[31:0], b[31:0], approx)) - 128'(64'(a[31:0]) * 64'(b[31:0]));
    e_hh = 128'(mulf(a[63:32], b[63:32], approx)) - 128'(64'(a[63:32]) * 64'(b[63:32]));
    e_rr = 128'(mulf(sa[31:0], sb[31:0], approx)) - 128'(64'(sa[31:0]) * 64'(sb[31:0]));
    r = 128'(a) * 128'(b);
    r = r + e_ll - (e_ll << 32) + (e_rr << 32) + (e_hh << 64) - (e_hh << 32);
    return r;
  endfunction

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Waits (bounded) for out_valid; lat counts cycles since the accept edge
  task automatic wait_result(output int lat);
    lat = 1;
    mx[1] = bus.mul_x;
    while (!bus.out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      if (lat <= 3) mx[lat] = bus.mul_x;
    end
  endtask

  // One full operation with out_ready held high
  task automatic run_op(input logic [63:0] ta, input logic [63:0] tb_v,
                        input logic [127:0] exp, input string tag);
    int lat;
    check({tag, "_in_ready"}, 128'(bus.in_ready), 128'(1));
    bus.a = ta;
    bus.b = tb_v;
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    wait_result(lat);
    check({tag, "_latency"}, 128'(lat), 128'(5));
    check({tag, "_p"}, bus.p, exp);
    @(posedge clk); #1;
    check({tag, "_ov_drop"}, 128'(bus.out_valid), 128'(0));
    check({tag, "_ready_back"}, 128'(bus.in_ready), 128'(1));
  endtask

  initial begin
    int lat;
    logic flag;
    logic [63:0] a1, b1, a2, b2;
    logic [127:0] held;

    n_checks = 0;
    n_errors = 0;
    use_approx = 1'b0;
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.out_ready = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 128'(bus.in_ready), 128'(1));
    check("rst_busy", 128'(bus.busy), 128'(0));
    check("rst_out_valid", 128'(bus.out_valid), 128'(0));
    check("rst_p", bus.p, 128'(0));
    check("rst_mul_x", 128'(bus.mul_x), 128'(0));
    check("rst_mul_y", 128'(bus.mul_y), 128'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed, exact multiplier
    run_op(64'd1, 64'd1, 128'd1, "one");
    run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
           128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001, "ones");
    run_op(64'h0000_0001_0000_0000, 64'h8000_0000_0000_0003,
           128'h0000_0000_8000_0000_0000_0003_0000_0000, "split");
    check("split_mx1", 128'(mx[1]), 128'(0));
    check("split_mx2", 128'(mx[2]), 128'(1));
    check("split_mx3", 128'(mx[3]), 128'(1));
    check("split_mx_hold", 128'(bus.mul_x), 128'(1));

    // Backpressure: 7 cycles of out_ready low, in_valid held high meanwhile
    a1 = {$urandom(), $urandom()};
    b1 = {$urandom(), $urandom()};
    a2 = {$urandom(), $urandom()};
    b2 = {$urandom(), $urandom()};
    bus.a = a1;
    bus.b = b1;
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b0;
    @(posedge clk); #1;
    bus.a = a2;
    bus.b = b2;
    wait_result(lat);
    check("bp_latency", 128'(lat), 128'(5));
    check("bp_p", bus.p, model(a1, b1, 1'b0));
    held = model(a1, b1, 1'b0);
    for (int i = 1; i < 7; i++) begin
      @(posedge clk); #1;
      check("bp_hold_p", bus.p, held);
      check("bp_hold_ov", 128'(bus.out_valid), 128'(1));
      check("bp_in_ready_low", 128'(bus.in_ready), 128'(0));
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_idle_ready", 128'(bus.in_ready), 128'(1));
    check("bp_idle_ov", 128'(bus.out_valid), 128'(0));
    @(posedge clk); #1;
    check("bp_next_accept", 128'(bus.busy), 128'(1));
    bus.in_valid = 1'b0;
    wait_result(lat);
    check("bp2_latency", 128'(lat), 128'(5));
    check("bp2_p", bus.p, model(a2, b2, 1'b0));
    @(posedge clk); #1;

    // Reset during MUL_HH
    bus.a = 64'hDEAD_BEEF_1234_5678;
    bus.b = 64'hCAFE_F00D_8765_4321;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("mrst_in_ready", 128'(bus.in_ready), 128'(1));
    check("mrst_busy", 128'(bus.busy), 128'(0));
    check("mrst_out_valid", 128'(bus.out_valid), 128'(0));
    check("mrst_p", bus.p, 128'(0));
    check("mrst_mul_x", 128'(bus.mul_x), 128'(0));
    check("mrst_mul_y", 128'(bus.mul_y), 128'(0));
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    flag = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
      if (bus.out_valid) flag = 1'b1;
    end
    check("mrst_no_spurious", 128'(flag), 128'(0));
    run_op(64'd3, 64'd5, 128'd15, "post_rst");

    // Random operands, approximate multiplier
    use_approx = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 1000; i++) begin
      a1 = {$urandom(), $urandom()};
      b1 = {$urandom(), $urandom()};
      if (i % 50 == 0) a1[63:32] = 32'hFFFF_FFFF;
      if (i % 70 == 0) b1 = '1;
      run_op(a1, b1, model(a1, b1, 1'b1), "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
